// File: rtl/pixel_store_pkg.sv
// rtl/pixel_store_pkg.sv - shared state encoding and space check for the pixel frame store
package pixel_store_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SER  = 2'd1,
    FULL = 2'd2,
    DONE = 2'd3
  } state_t;

  // True when a whole pixel of `channels` entries still fits behind `ptr`.
  function automatic logic has_space(input logic [31:0] ptr, input int channels, input int depth);
    return (ptr + 32'(channels)) <= 32'(depth);
  endfunction

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port frame buffer, one write port and one registered read port
module frame_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 51200,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-during-write to the same address returns the previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pixel_frame_store.sv
// rtl/pixel_frame_store.sv - serialises multi-channel pixels into the frame buffer, tracks fill and frame end
module pixel_frame_store
  import pixel_store_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 51200,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_pixel,
  input  logic                       in_last,
  input  logic                       frame_clr,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [ADDR_W:0]            wr_ptr,
  output logic [ADDR_W:0]            px_count,
  output logic                       frame_done,
  output logic                       full,
  output logic                       overflow
);

  localparam int PW = CHANNELS * DATA_W;
  localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [KW-1:0]   LAST_K  = KW'(CHANNELS - 1);
  localparam logic [ADDR_W:0] CH_STEP = (ADDR_W + 1)'(CHANNELS);

  state_t            state;
  logic [KW-1:0]     k;
  logic [PW-1:0]     pix_q;
  logic              last_q;
  logic [ADDR_W-1:0] ch_addr;

  logic              space;
  logic              next_space;
  logic [ADDR_W:0]   next_ptr;
  logic              accept;
  logic              finish;
  logic              fin_last;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    space      = has_space(32'(wr_ptr), CHANNELS, DEPTH);
    next_ptr   = wr_ptr + CH_STEP;
    next_space = has_space(32'(next_ptr), CHANNELS, DEPTH);
    in_ready   = (state == IDLE) && space;
    accept     = in_valid && in_ready;
    finish     = ((state == IDLE) && accept && (CHANNELS == 1)) ||
                 ((state == SER) && (k == LAST_K));
    fin_last   = (state == SER) ? last_q : in_last;
    // An abandoned pixel must not touch RAM in the clearing cycle.
    we         = !frame_clr && (((state == IDLE) && accept) || (state == SER));
    wr_addr    = (state == SER) ? ch_addr : wr_ptr[ADDR_W-1:0];
    wr_data    = (state == SER) ? pix_q[DATA_W-1:0] : in_pixel[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || frame_clr) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      px_count   <= '0;
      frame_done <= 1'b0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      k          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pix_q   <= in_pixel >> DATA_W;
            last_q  <= in_last;
            ch_addr <= wr_ptr[ADDR_W-1:0] + ADDR_W'(1);
            k       <= KW'(1);
            state   <= SER;
          end
        end
        SER: begin
          pix_q   <= pix_q >> DATA_W;
          ch_addr <= ch_addr + ADDR_W'(1);
          k       <= k + KW'(1);
        end
        FULL: begin
          if (in_valid) begin
            overflow <= 1'b1;
          end
        end
        default: begin
        end
      endcase

      // Completing a pixel overrides the per-state next-state choice above.
      if (finish) begin
        wr_ptr   <= next_ptr;
        px_count <= px_count + (ADDR_W + 1)'(1);
        if (!next_space) begin
          full <= 1'b1;
        end
        if (fin_last) begin
          frame_done <= 1'b1;
          state      <= DONE;
        end else if (!next_space) begin
          state <= FULL;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_pixel_frame_store.sv
// tb/tb_pixel_frame_store.sv - scoreboard bench for pixel_frame_store in RGB, short-buffer and grayscale configs
module tb_pixel_frame_store;

  localparam int F_RDY  = 0;
  localparam int F_PTR  = 1;
  localparam int F_PX   = 2;
  localparam int F_DONE = 3;
  localparam int F_FULL = 4;
  localparam int F_OVF  = 5;
  localparam int F_RD   = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_in_valid, a_in_ready, a_in_last, a_frame_clr, a_rd_en, a_frame_done, a_full, a_overflow;
  logic [23:0] a_in_pixel;
  logic [3:0]  a_rd_addr;
  logic [7:0]  a_rd_data;
  logic [4:0]  a_wr_ptr, a_px_count;

  logic b_in_valid, b_in_ready, b_in_last, b_frame_clr, b_rd_en, b_frame_done, b_full, b_overflow;
  logic [23:0] b_in_pixel;
  logic [3:0]  b_rd_addr;
  logic [7:0]  b_rd_data;
  logic [4:0]  b_wr_ptr, b_px_count;

  logic c_in_valid, c_in_ready, c_in_last, c_frame_clr, c_rd_en, c_frame_done, c_full, c_overflow;
  logic [7:0]  c_in_pixel;
  logic [3:0]  c_rd_addr;
  logic [7:0]  c_rd_data;
  logic [4:0]  c_wr_ptr, c_px_count;

  pixel_frame_store #(.DATA_W(8), .CHANNELS(3), .DEPTH(12)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pixel(a_in_pixel),
    .in_last(a_in_last), .frame_clr(a_frame_clr), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .wr_ptr(a_wr_ptr), .px_count(a_px_count), .frame_done(a_frame_done),
    .full(a_full), .overflow(a_overflow)
  );

  pixel_frame_store #(.DATA_W(8), .CHANNELS(3), .DEPTH(10)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
    .in_last(b_in_last), .frame_clr(b_frame_clr), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .wr_ptr(b_wr_ptr), .px_count(b_px_count), .frame_done(b_frame_done),
    .full(b_full), .overflow(b_overflow)
  );

  pixel_frame_store #(.DATA_W(8), .CHANNELS(1), .DEPTH(16)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_pixel(c_in_pixel),
    .in_last(c_in_last), .frame_clr(c_frame_clr), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
    .rd_data(c_rd_data), .wr_ptr(c_wr_ptr), .px_count(c_px_count), .frame_done(c_frame_done),
    .full(c_full), .overflow(c_overflow)
  );

  typedef struct {
    string name;
    int    dut;
    int    field;
    int    exp;
  } chk_t;

  typedef struct {
    int dut;
    int addr;
    int exp;
  } rd_t;

  chk_t sq[$];
  rd_t  rdq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [2:0] rd_pend = 3'b000;

  function automatic int get_field(input int d, input int f);
    case (d)
      0: case (f)
           F_RDY: return int'(a_in_ready);   F_PTR: return int'(a_wr_ptr);
           F_PX:  return int'(a_px_count);   F_DONE: return int'(a_frame_done);
           F_FULL: return int'(a_full);      F_OVF: return int'(a_overflow);
           default: return int'(a_rd_data);
         endcase
      1: case (f)
           F_RDY: return int'(b_in_ready);   F_PTR: return int'(b_wr_ptr);
           F_PX:  return int'(b_px_count);   F_DONE: return int'(b_frame_done);
           F_FULL: return int'(b_full);      F_OVF: return int'(b_overflow);
           default: return int'(b_rd_data);
         endcase
      default: case (f)
           F_RDY: return int'(c_in_ready);   F_PTR: return int'(c_wr_ptr);
           F_PX:  return int'(c_px_count);   F_DONE: return int'(c_frame_done);
           F_FULL: return int'(c_full);      F_OVF: return int'(c_overflow);
           default: return int'(c_rd_data);
         endcase
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) rd_pend <= {c_rd_en, b_rd_en, a_rd_en};

  always @(negedge clk) begin : monitor
    chk_t e;
    rd_t  r;
    while (sq.size() > 0) begin
      e = sq.pop_front();
      check(e.name, get_field(e.dut, e.field), e.exp);
    end
    for (int d = 0; d < 3; d++) begin
      if (rd_pend[d]) begin
        if (rdq.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: dut %0d returned data with no read queued", d);
        end else begin
          r = rdq.pop_front();
          check($sformatf("rd_d%0d_a%0d", d, r.addr), get_field(d, F_RD), (r.dut == d) ? r.exp : -1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string name, input int d, input int f, input int e);
    chk_t c;
    c.name = name; c.dut = d; c.field = f; c.exp = e;
    sq.push_back(c);
  endtask

  task automatic drive(input int d, input logic v, input logic [23:0] px, input logic last);
    case (d)
      0: begin a_in_valid = v; a_in_pixel = px; a_in_last = last; end
      1: begin b_in_valid = v; b_in_pixel = px; b_in_last = last; end
      default: begin c_in_valid = v; c_in_pixel = px[7:0]; c_in_last = last; end
    endcase
  endtask

  task automatic set_clr(input int d, input logic v);
    case (d)
      0: a_frame_clr = v;
      1: b_frame_clr = v;
      default: c_frame_clr = v;
    endcase
  endtask

  task automatic do_read(input int d, input int addr, input int e);
    rd_t r;
    r.dut = d; r.addr = addr; r.exp = e;
    case (d)
      0: begin a_rd_en = 1'b1; a_rd_addr = 4'(addr); end
      1: begin b_rd_en = 1'b1; b_rd_addr = 4'(addr); end
      default: begin c_rd_en = 1'b1; c_rd_addr = 4'(addr); end
    endcase
    rdq.push_back(r);
    tick();
    a_rd_en = 1'b0; b_rd_en = 1'b0; c_rd_en = 1'b0;
  endtask

  task automatic send_px(input int d, input logic [23:0] px, input logic last, input int ch);
    drive(d, 1'b1, px, last);
    tick();
    drive(d, 1'b0, 24'h0, 1'b0);
    repeat (ch - 1) tick();
  endtask

  task automatic expect_flags(input string tag, input int d, input int rdy, input int ptr, input int px,
                              input int done, input int fl, input int ovf);
    expect_st({tag, "_ready"}, d, F_RDY, rdy);
    expect_st({tag, "_wr_ptr"}, d, F_PTR, ptr);
    expect_st({tag, "_px_count"}, d, F_PX, px);
    expect_st({tag, "_frame_done"}, d, F_DONE, done);
    expect_st({tag, "_full"}, d, F_FULL, fl);
    expect_st({tag, "_overflow"}, d, F_OVF, ovf);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [23:0] pix [4];
    logic [23:0] px;
    pix[0] = 24'h030201; pix[1] = 24'h060504; pix[2] = 24'h090807; pix[3] = 24'h0C0B0A;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 24'h0, 1'b0);
      set_clr(d, 1'b0);
    end
    a_rd_en = 1'b0; b_rd_en = 1'b0; c_rd_en = 1'b0;
    a_rd_addr = '0; b_rd_addr = '0; c_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    expect_flags("a_reset", 0, 1, 0, 0, 0, 0, 0);
    expect_st("a_reset_rd_data", 0, F_RD, 0);
    expect_st("b_reset_ready", 1, F_RDY, 1);
    expect_st("c_reset_rd_data", 2, F_RD, 0);
    tick();

    // Three RGB pixels back to back with in_valid held high.
    for (int i = 0; i < 9; i++) begin
      drive(0, 1'b1, pix[i / 3], 1'b0);
      expect_st($sformatf("a_ready_pat_%0d", i), 0, F_RDY, (i % 3 == 0) ? 1 : 0);
      tick();
    end
    drive(0, 1'b0, 24'h0, 1'b0);
    expect_flags("a_three_px", 0, 1, 9, 3, 0, 0, 0);
    for (int i = 0; i < 9; i++) do_read(0, i, i + 1);

    // Last pixel fills the buffer exactly: frame_done and full together.
    send_px(0, pix[3], 1'b1, 3);
    expect_flags("a_last_px", 0, 0, 12, 4, 1, 1, 0);
    drive(0, 1'b1, 24'hAAAAAA, 1'b0);
    tick();
    drive(0, 1'b0, 24'h0, 1'b0);
    expect_st("a_done_no_ovf", 0, F_OVF, 0);
    expect_st("a_done_ptr_hold", 0, F_PTR, 12);
    for (int i = 9; i < 12; i++) do_read(0, i, i + 1);

    set_clr(0, 1'b1);
    tick();
    set_clr(0, 1'b0);
    expect_flags("a_clr", 0, 1, 0, 0, 0, 0, 0);
    tick();

    // Fill without in_last, then offer a pixel while full.
    for (int j = 0; j < 4; j++) begin
      px = {8'(8'h13 + 3 * j), 8'(8'h12 + 3 * j), 8'(8'h11 + 3 * j)};
      send_px(0, px, 1'b0, 3);
    end
    expect_flags("a_filled", 0, 0, 12, 4, 0, 1, 0);
    drive(0, 1'b1, 24'hFFFFFF, 1'b0);
    tick();
    drive(0, 1'b0, 24'h0, 1'b0);
    expect_st("a_ovf_set", 0, F_OVF, 1);
    expect_st("a_ovf_ptr", 0, F_PTR, 12);
    expect_st("a_ovf_px", 0, F_PX, 4);
    tick();
    expect_st("a_ovf_sticky", 0, F_OVF, 1);
    for (int i = 0; i < 12; i++) do_read(0, i, 8'h11 + i);

    // frame_clr during the second serialisation cycle abandons the pixel.
    set_clr(0, 1'b1);
    tick();
    set_clr(0, 1'b0);
    drive(0, 1'b1, 24'h232221, 1'b0);
    tick();
    drive(0, 1'b0, 24'h0, 1'b0);
    tick();
    set_clr(0, 1'b1);
    tick();
    set_clr(0, 1'b0);
    expect_flags("a_mid_clr", 0, 1, 0, 0, 0, 0, 0);
    send_px(0, 24'h333231, 1'b0, 3);
    expect_st("a_after_clr_ptr", 0, F_PTR, 3);
    expect_st("a_after_clr_px", 0, F_PX, 1);
    for (int i = 0; i < 3; i++) do_read(0, i, 8'h31 + i);
    do_read(0, 3, 8'h14);

    // DEPTH=10: a fourth pixel would need entries 9..11, so stop at 9.
    for (int j = 0; j < 3; j++) send_px(1, pix[j], 1'b0, 3);
    expect_flags("b_full", 1, 0, 9, 3, 0, 1, 0);
    drive(1, 1'b1, 24'h0D0C0B, 1'b0);
    tick();
    drive(1, 1'b0, 24'h0, 1'b0);
    expect_st("b_ovf", 1, F_OVF, 1);
    expect_st("b_no_partial_ptr", 1, F_PTR, 9);
    do_read(1, 8, 8'h09);

    // Grayscale: one sample per cycle with in_ready held high.
    for (int i = 0; i < 4; i++) begin
      drive(2, 1'b1, 24'(8'h41 + i), 1'b0);
      expect_st($sformatf("c_ready_%0d", i), 2, F_RDY, 1);
      tick();
    end
    drive(2, 1'b0, 24'h0, 1'b0);
    expect_st("c_ptr", 2, F_PTR, 4);
    expect_st("c_px", 2, F_PX, 4);
    expect_st("c_full", 2, F_FULL, 0);
    do_read(2, 2, 8'h43);
    tick();
    tick();
    expect_st("c_rd_hold", 2, F_RD, 8'h43);
    tick();

    for (int i = 0; i < 20 && (sq.size() > 0 || rdq.size() > 0); i++) tick();
    if (sq.size() > 0 || rdq.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d status and %0d read checks still pending, required 0", sq.size(), rdq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_frame_store.md
# pixel_frame_store

Parametrised successor to the grayscale/RGB result store in the Sobel pipeline. It accepts multi-channel pixels over a valid/ready handshake and serialises the channels into an internal single-write-port frame buffer, one entry per cycle. It tracks fill level, end-of-frame and overflow, and exposes a registered read port so the downstream Sobel/readout stage can fetch stored samples.

## Interface
- DATA_W, 8, bits per channel sample
- CHANNELS, 3, channels per pixel (1 = grayscale, 3 = RGB); must be ≥1 and ≤ DEPTH
- DEPTH, 51200, buffer entries (one channel sample per entry)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pixel offered
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_pixel  in  CHANNELS*DATA_W  packed pixel; channel 0 (red) in LSBs
- in_last  in  1  marks final pixel of frame, sampled with the pixel
- frame_clr  in  1  rewind buffer, clear flags
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- wr_ptr  out  ADDR_W+1  entries written so far
- px_count  out  ADDR_W+1  pixels fully stored
- frame_done  out  1  level: last pixel fully stored
- full  out  1  level: next pixel does not fit
- overflow  out  1  sticky: pixel offered while full

## Operation
- States: IDLE, SER, FULL, DONE.
- IDLE: in_ready = 1 iff wr_ptr + CHANNELS ≤ DEPTH. On accept, write channel 0 at wr_ptr, latch the pixel and in_last, set k=1, and go to SER (if CHANNELS>1) or finish the pixel.
- SER: in_ready = 0. Each cycle, write channel k at wr_ptr + k and increment k. After channel CHANNELS-1 the pixel finishes.
- Finishing a pixel:
  - wr_ptr += CHANNELS and px_count += 1.
  - If the latched last flag is set, go to DONE.
  - Otherwise, if wr_ptr + CHANNELS > DEPTH (new value), go to FULL.
  - Otherwise, go to IDLE.
- FULL: full = 1, in_ready = 0. in_valid sets overflow; the pixel is dropped and not stalled.
- DONE: frame_done = 1, in_ready = 0. in_valid is held off without setting overflow.
- frame_clr has priority in every state:
  - next cycle: wr_ptr = 0, px_count = 0, all flags cleared, state IDLE;
  - a pixel mid-SER is abandoned; entries already written remain in RAM but are not counted.
- rst has the same effect as frame_clr and also forces rd_data = 0. RAM contents are not reset.
- Arithmetic: pointer compares use ADDR_W+1 bits, so there is no wrap-around. A partial pixel is never written at the end of the buffer.

## Timing
- Throughput: one pixel per CHANNELS cycles. in_ready is deasserted for CHANNELS-1 cycles after each accept.
- Write of channel 0 happens in the accept cycle. The last channel is written CHANNELS-1 cycles later.
- wr_ptr, px_count, frame_done and full update on the edge after the last channel write.
- in_ready is combinational from state and wr_ptr only, never from in_valid.
- Read: rd_data is valid 1 cycle after rd_en and holds when rd_en = 0. Read-during-write to the same address returns the old data.
- Reset values:
  - in_ready = 1 (first cycle after rst deasserts);
  - rd_data, wr_ptr, px_count, frame_done, full, overflow = 0.

## Structure
- Package pixel_store_pkg:
  - state enum (IDLE/SER/FULL/DONE);
  - function computing the space check from wr_ptr, CHANNELS and DEPTH.
- Sub-module frame_ram: simple dual-port RAM, 1 write / 1 registered read, parametrised on DATA_W and DEPTH, inferable to block RAM.
- Top level holds the FSM, channel counter, pixel latch and flags.

## Test plan
- CHANNELS=3, DEPTH=12: send pixels 0x030201, 0x060504, 0x090807 back-to-back with in_valid held high.
  - in_ready pattern is 1,0,0 repeating.
  - RAM[0..8] = 01..09.
  - px_count = 3, wr_ptr = 9.
- Same config, 4th pixel with in_last = 1. Expect frame_done = 1, then full = 1 after wr_ptr = 12.
- Same config, buffer full, in_valid pulsed. Expect overflow = 1 (sticky), wr_ptr unchanged at 12, RAM unchanged.
- DEPTH=10: after 3 pixels (wr_ptr = 9), full = 1 and in_ready = 0. No partial write to entry 9.
- frame_clr asserted in the second SER cycle of a pixel. Next cycle: state IDLE, wr_ptr = 0, px_count = 0, flags clear. A following pixel lands at address 0.
- CHANNELS=1 (grayscale): in_ready stays high and 1 pixel/cycle is stored. rd_en with rd_addr = 2 returns the third sample one cycle later.
